// File: rtl/pcie_tl_tx_scheduler.sv
// pcie_tl_tx_scheduler: credit-gated round-robin arbiter of P/NP/CPL TLPs onto the TL->DLL beat stream.
// Define PCIE_TX_CPL_PRIO_EN to grant eligible completions ahead of P/NP round-robin.
module pcie_tl_tx_scheduler #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int CREDIT_DEPTH = 12,
  parameter int RETRY_DEPTH_LG2 = 8,
  parameter int BEATS_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic p_valid_i,
  input  logic np_valid_i,
  input  logic cpl_valid_i,
  input  logic [PIPE_DATA_WIDTH-1:0] p_data_i,
  input  logic [PIPE_DATA_WIDTH-1:0] np_data_i,
  input  logic [PIPE_DATA_WIDTH-1:0] cpl_data_i,
  input  logic [BEATS_W-1:0] p_beats_i,
  input  logic [BEATS_W-1:0] cpl_beats_i,
  output logic p_ready_o,
  output logic np_ready_o,
  output logic cpl_ready_o,
  input  logic [CREDIT_DEPTH-1:0] cl_ph_i,
  input  logic [CREDIT_DEPTH-1:0] cl_pd_i,
  input  logic [CREDIT_DEPTH-1:0] cl_nh_i,
  input  logic [CREDIT_DEPTH-1:0] cl_ch_i,
  input  logic [CREDIT_DEPTH-1:0] cl_cd_i,
  input  logic [2:0] link_active_i,
  input  logic [RETRY_DEPTH_LG2-1:0] retry_free_i,
  output logic [PIPE_DATA_WIDTH-1:0] tlp_o,
  output logic [2:0] req_o,
  output logic [CREDIT_DEPTH-1:0] cc_ph_o,
  output logic [CREDIT_DEPTH-1:0] cc_pd_o,
  output logic [CREDIT_DEPTH-1:0] cc_nh_o,
  output logic [CREDIT_DEPTH-1:0] cc_ch_o,
  output logic [CREDIT_DEPTH-1:0] cc_cd_o
);
  localparam int CW = CREDIT_DEPTH;
  localparam int RW = RETRY_DEPTH_LG2;
  localparam logic [CW-1:0] HALF = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [2:0] R_IDLE = 3'd0, R_P_HDR = 3'd1, R_P_DATA = 3'd2, R_NP_HDR = 3'd3, R_CPL_HDR = 3'd5, R_CPL_DATA = 3'd6;
  typedef enum logic {S_IDLE, S_DATA} state_t;
  state_t state, state_n;
  logic [1:0] ptr, owner, sel, c1, c2;
  logic [BEATS_W-1:0] cnt, sel_beats;
  logic [CW-1:0] p_need, cpl_need;
  logic [2:0] elig;
  logic any, acc;
  // Limit is ahead of consumed+need by at most half the counter range.
  function automatic logic fc_ok(input logic [CW-1:0] cl, input logic [CW-1:0] cc, input logic [CW-1:0] need);
    logic [CW-1:0] d;
    d = cl - cc - need;
    return d <= HALF;
  endfunction
  assign p_need = {{(CW-BEATS_W-1){1'b0}}, p_beats_i, 1'b0};
  assign cpl_need = {{(CW-BEATS_W-1){1'b0}}, cpl_beats_i, 1'b0};
  assign elig[0] = p_valid_i & link_active_i[0] & fc_ok(cl_ph_i, cc_ph_o, ONE) & fc_ok(cl_pd_i, cc_pd_o, p_need)
                   & (retry_free_i >= RW'(p_beats_i) + RW'(1));
  assign elig[1] = np_valid_i & link_active_i[1] & fc_ok(cl_nh_i, cc_nh_o, ONE) & (retry_free_i >= RW'(1));
  assign elig[2] = cpl_valid_i & link_active_i[2] & fc_ok(cl_ch_i, cc_ch_o, ONE) & fc_ok(cl_cd_i, cc_cd_o, cpl_need)
                   & (retry_free_i >= RW'(cpl_beats_i) + RW'(1));
  assign any = |elig;
  assign c1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  assign c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
`ifdef PCIE_TX_CPL_PRIO_EN
  assign sel = elig[2] ? 2'd2 : elig[ptr] ? ptr : {1'b0, ~ptr[0]};
`else
  assign sel = elig[ptr] ? ptr : elig[c1] ? c1 : c2;
`endif
  assign sel_beats = (sel == 2'd0) ? p_beats_i : (sel == 2'd2) ? cpl_beats_i : '0;
  assign acc = (owner == 2'd0) ? p_valid_i : cpl_valid_i;
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == S_IDLE) ? ((any && sel_beats != '0) ? S_DATA : S_IDLE)
                                : ((acc && cnt == BEATS_W'(1)) ? S_IDLE : S_DATA);
  always_comb begin
    p_ready_o = !rst && ((state == S_IDLE) ? (any && sel == 2'd0) : (owner == 2'd0 && p_valid_i));
    np_ready_o = !rst && state == S_IDLE && any && sel == 2'd1;
    cpl_ready_o = !rst && ((state == S_IDLE) ? (any && sel == 2'd2) : (owner == 2'd2 && cpl_valid_i));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tlp_o <= '0;
      req_o <= R_IDLE;
      {cc_ph_o, cc_pd_o, cc_nh_o, cc_ch_o, cc_cd_o} <= '0;
      ptr <= 2'd0;
      owner <= 2'd0;
      cnt <= '0;
    end else if (state == S_IDLE) begin
      if (any) begin
        tlp_o <= (sel == 2'd0) ? p_data_i : (sel == 2'd1) ? np_data_i : cpl_data_i;
        req_o <= (sel == 2'd0) ? R_P_HDR : (sel == 2'd1) ? R_NP_HDR : R_CPL_HDR;
        owner <= sel;
        cnt <= sel_beats;
`ifdef PCIE_TX_CPL_PRIO_EN
        if (sel != 2'd2) ptr <= (sel == 2'd0) ? 2'd1 : 2'd0;
`else
        ptr <= c1 == 2'd0 && sel == 2'd2 ? 2'd0 : (sel == 2'd2) ? 2'd0 : sel + 2'd1;
`endif
        if (sel == 2'd0) begin
          cc_ph_o <= cc_ph_o + ONE;
          cc_pd_o <= cc_pd_o + p_need;
        end
        if (sel == 2'd1) cc_nh_o <= cc_nh_o + ONE;
        if (sel == 2'd2) begin
          cc_ch_o <= cc_ch_o + ONE;
          cc_cd_o <= cc_cd_o + cpl_need;
        end
      end else begin
        req_o <= R_IDLE;
      end
    end else if (acc) begin
      tlp_o <= (owner == 2'd0) ? p_data_i : cpl_data_i;
      req_o <= (owner == 2'd0) ? R_P_DATA : R_CPL_DATA;
      cnt <= cnt - BEATS_W'(1);
    end else begin
      req_o <= R_IDLE;
    end
  end
endmodule

// File: tb/tb_pcie_tl_tx_scheduler.sv
// tb_pcie_tl_tx_scheduler: directed self-checking bench for pcie_tl_tx_scheduler.
module tb_pcie_tl_tx_scheduler;
  logic clk = 0, rst = 1;
  logic p_valid_i = 0, np_valid_i = 0, cpl_valid_i = 0;
  logic [255:0] p_data_i = '0, np_data_i = '0, cpl_data_i = '0;
  logic [2:0] p_beats_i = 0, cpl_beats_i = 0;
  logic p_ready_o, np_ready_o, cpl_ready_o;
  logic [11:0] cl_ph_i = 0, cl_pd_i = 0, cl_nh_i = 0, cl_ch_i = 0, cl_cd_i = 0;
  logic [2:0] link_active_i = 3'b111;
  logic [7:0] retry_free_i = 8'd255;
  logic [255:0] tlp_o;
  logic [2:0] req_o;
  logic [11:0] cc_ph_o, cc_pd_o, cc_nh_o, cc_ch_o, cc_cd_o;
  int errors = 0, checks = 0;

  pcie_tl_tx_scheduler dut (
    .clk(clk), .rst(rst),
    .p_valid_i(p_valid_i), .np_valid_i(np_valid_i), .cpl_valid_i(cpl_valid_i),
    .p_data_i(p_data_i), .np_data_i(np_data_i), .cpl_data_i(cpl_data_i),
    .p_beats_i(p_beats_i), .cpl_beats_i(cpl_beats_i),
    .p_ready_o(p_ready_o), .np_ready_o(np_ready_o), .cpl_ready_o(cpl_ready_o),
    .cl_ph_i(cl_ph_i), .cl_pd_i(cl_pd_i), .cl_nh_i(cl_nh_i), .cl_ch_i(cl_ch_i), .cl_cd_i(cl_cd_i),
    .link_active_i(link_active_i), .retry_free_i(retry_free_i),
    .tlp_o(tlp_o), .req_o(req_o),
    .cc_ph_o(cc_ph_o), .cc_pd_o(cc_pd_o), .cc_nh_o(cc_nh_o), .cc_ch_o(cc_ch_o), .cc_cd_o(cc_cd_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1;
    {p_valid_i, np_valid_i, cpl_valid_i} = 3'b000;
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    p_valid_i = 1;
    cl_ph_i = 12'd10;
    cl_pd_i = 12'd10;
    tick();
    checks++;
    if (req_o !== 3'd0) begin errors++; $display("FAIL reset_req got=%0d exp=0", req_o); end
    checks++;
    if (tlp_o !== '0) begin errors++; $display("FAIL reset_tlp got=%h exp=0", tlp_o); end
    checks++;
    if ({cc_ph_o, cc_pd_o, cc_nh_o, cc_ch_o, cc_cd_o} !== '0) begin errors++; $display("FAIL reset_cc got ph=%0d pd=%0d exp=0", cc_ph_o, cc_pd_o); end
    checks++;
    if (p_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", p_ready_o); end
    p_valid_i = 0;
    rst = 0;
  endtask

  task automatic test_credit_block;
    do_reset();
    cl_ph_i = 12'd1;
    cl_pd_i = 12'd8;
    p_valid_i = 1;
    p_beats_i = 3'd4;
    p_data_i = 256'h100;
    #1;
    checks++;
    if (p_ready_o !== 1'b1) begin errors++; $display("FAIL t1_grant_ready got=%b exp=1", p_ready_o); end
    tick();
    checks++;
    if (req_o !== 3'd1 || tlp_o !== 256'h100) begin errors++; $display("FAIL t1_hdr got req=%0d tlp=%h exp req=1 tlp=100", req_o, tlp_o); end
    checks++;
    if (cc_ph_o !== 12'd1 || cc_pd_o !== 12'd8) begin errors++; $display("FAIL t1_cc got ph=%0d pd=%0d exp ph=1 pd=8", cc_ph_o, cc_pd_o); end
    for (int b = 1; b <= 4; b++) begin
      p_data_i = 256'h100 + 256'(b);
      tick();
      checks++;
      if (req_o !== 3'd2 || tlp_o !== 256'h100 + 256'(b)) begin errors++; $display("FAIL t1_data%0d got req=%0d tlp=%h exp req=2", b, req_o, tlp_o); end
    end
    p_data_i = 256'h200;
    #1;
    checks++;
    if (p_ready_o !== 1'b0) begin errors++; $display("FAIL t1_block_ready got=%b exp=0", p_ready_o); end
    tick();
    checks++;
    if (req_o !== 3'd0 || tlp_o !== 256'h104) begin errors++; $display("FAIL t1_block got req=%0d tlp=%h exp req=0 tlp=104", req_o, tlp_o); end
    cl_ph_i = 12'd2;
    cl_pd_i = 12'd16;
    tick();
    checks++;
    if (req_o !== 3'd1 || tlp_o !== 256'h200) begin errors++; $display("FAIL t1_regrant got req=%0d tlp=%h exp req=1 tlp=200", req_o, tlp_o); end
    checks++;
    if (cc_ph_o !== 12'd2 || cc_pd_o !== 12'd16) begin errors++; $display("FAIL t1_cc2 got ph=%0d pd=%0d exp ph=2 pd=16", cc_ph_o, cc_pd_o); end
    p_valid_i = 0;
  endtask

  task automatic test_bubble;
    do_reset();
    cl_ph_i = 12'd100;
    cl_pd_i = 12'd100;
    p_valid_i = 1;
    p_beats_i = 3'd2;
    p_data_i = 256'h300;
    tick();
    p_data_i = 256'h301;
    tick();
    checks++;
    if (req_o !== 3'd2) begin errors++; $display("FAIL bub_data1 got=%0d exp=2", req_o); end
    p_valid_i = 0;
    tick();
    checks++;
    if (req_o !== 3'd0 || tlp_o !== 256'h301) begin errors++; $display("FAIL bub_idle got req=%0d tlp=%h exp req=0 tlp=301", req_o, tlp_o); end
    p_valid_i = 1;
    p_data_i = 256'h302;
    tick();
    checks++;
    if (req_o !== 3'd2 || tlp_o !== 256'h302) begin errors++; $display("FAIL bub_data2 got req=%0d tlp=%h exp req=2 tlp=302", req_o, tlp_o); end
    p_valid_i = 0;
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_seq [6];
`ifdef PCIE_TX_CPL_PRIO_EN
    exp_seq = '{3'd5, 3'd5, 3'd5, 3'd1, 3'd3, 3'd1};
`else
    exp_seq = '{3'd1, 3'd3, 3'd5, 3'd1, 3'd3, 3'd5};
`endif
    do_reset();
    {cl_ph_i, cl_pd_i, cl_nh_i, cl_ch_i, cl_cd_i} = {5{12'd100}};
    p_beats_i = 0;
    cpl_beats_i = 0;
    {p_valid_i, np_valid_i, cpl_valid_i} = 3'b111;
    for (int i = 0; i < 6; i++) begin
`ifdef PCIE_TX_CPL_PRIO_EN
      if (i == 3) cpl_valid_i = 0;
`endif
      tick();
      checks++;
      if (req_o !== exp_seq[i]) begin errors++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, req_o, exp_seq[i]); end
    end
`ifndef PCIE_TX_CPL_PRIO_EN
    checks++;
    if (cc_ph_o !== 12'd2 || cc_nh_o !== 12'd2 || cc_ch_o !== 12'd2) begin errors++; $display("FAIL rr_cc got ph=%0d nh=%0d ch=%0d exp 2/2/2", cc_ph_o, cc_nh_o, cc_ch_o); end
`endif
    {p_valid_i, np_valid_i, cpl_valid_i} = 3'b000;
  endtask

  task automatic test_wrap;
    do_reset();
    cl_pd_i = 12'd0;
    p_beats_i = 0;
    p_valid_i = 1;
    for (int i = 0; i < 4095; i++) begin
      cl_ph_i = 12'(i + 1);
      tick();
    end
    checks++;
    if (cc_ph_o !== 12'd4095) begin errors++; $display("FAIL wrap_pre got=%0d exp=4095", cc_ph_o); end
    cl_ph_i = 12'd0;
    #1;
    checks++;
    if (p_ready_o !== 1'b1) begin errors++; $display("FAIL wrap_ready got=%b exp=1", p_ready_o); end
    tick();
    checks++;
    if (cc_ph_o !== 12'd0 || req_o !== 3'd1) begin errors++; $display("FAIL wrap_cc got ph=%0d req=%0d exp ph=0 req=1", cc_ph_o, req_o); end
    p_valid_i = 0;
  endtask

  task automatic test_retry;
    do_reset();
    cl_ch_i = 12'd10;
    cl_cd_i = 12'd100;
    cpl_beats_i = 3'd4;
    cpl_valid_i = 1;
    retry_free_i = 8'd4;
    #1;
    checks++;
    if (cpl_ready_o !== 1'b0) begin errors++; $display("FAIL retry_block_ready got=%b exp=0", cpl_ready_o); end
    tick();
    checks++;
    if (req_o !== 3'd0) begin errors++; $display("FAIL retry_block got=%0d exp=0", req_o); end
    retry_free_i = 8'd5;
    #1;
    checks++;
    if (cpl_ready_o !== 1'b1) begin errors++; $display("FAIL retry_ready got=%b exp=1", cpl_ready_o); end
    tick();
    checks++;
    if (req_o !== 3'd5 || cc_cd_o !== 12'd8) begin errors++; $display("FAIL retry_grant got req=%0d cd=%0d exp req=5 cd=8", req_o, cc_cd_o); end
    cpl_valid_i = 0;
    retry_free_i = 8'd255;
  endtask

  task automatic test_reset_mid;
    do_reset();
    cl_ph_i = 12'd100;
    cl_pd_i = 12'd100;
    p_beats_i = 3'd4;
    p_valid_i = 1;
    tick();
    tick();
    checks++;
    if (req_o !== 3'd2) begin errors++; $display("FAIL mid_data1 got=%0d exp=2", req_o); end
    rst = 1;
    #1;
    checks++;
    if (p_ready_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", p_ready_o); end
    tick();
    rst = 0;
    p_valid_i = 0;
    #1;
    checks++;
    if (req_o !== 3'd0 || cc_ph_o !== 12'd0 || cc_pd_o !== 12'd0 || p_ready_o !== 1'b0) begin
      errors++; $display("FAIL mid_abort got req=%0d ph=%0d pd=%0d rdy=%b exp 0", req_o, cc_ph_o, cc_pd_o, p_ready_o);
    end
    p_valid_i = 1;
    p_beats_i = 0;
    p_data_i = 256'h400;
    tick();
    checks++;
    if (req_o !== 3'd1 || tlp_o !== 256'h400 || cc_ph_o !== 12'd1) begin errors++; $display("FAIL mid_resume got req=%0d ph=%0d exp req=1 ph=1", req_o, cc_ph_o); end
    p_valid_i = 0;
  endtask

  initial begin
    test_reset();
    test_credit_block();
    test_bubble();
    test_round_robin();
    test_wrap();
    test_retry();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
